// File: rtl/i2c_bus_filter_if.sv
// Bus-side signal bundle for the I2C input conditioning stage.
// master drives the raw lines; slave is the filter producing clean levels.
interface i2c_bus_filter_if;
    logic scl_in;
    logic sda_in;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;
    logic scl_tmo;

    modport master (
        output scl_in, sda_in,
        input  scl_f, sda_f, scl_rise, scl_fall,
        input  start_det, stop_det, bus_busy, scl_tmo
    );

    modport slave (
        input  scl_in, sda_in,
        output scl_f, sda_f, scl_rise, scl_fall,
        output start_det, stop_det, bus_busy, scl_tmo
    );
endinterface

// File: rtl/i2c_bus_filter.sv
// I2C bus input filter: sync, spike reject, edge/START/STOP strobes, busy.
// Optional SCL-low timeout built when I2C_BUS_FILTER_SCL_TMO_EN is defined.
module i2c_bus_filter #(
    parameter int FILT_W = 4,
    parameter int TMO_W  = 16
) (
    input  logic              wclk,
    input  logic              srst,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [TMO_W-1:0]  tmo_len,
    i2c_bus_filter_if.slave   bus
);

    logic              scl_s1, scl_s2;
    logic              sda_s1, sda_s2;
    logic [FILT_W-1:0] scl_cnt, sda_cnt;
    logic              scl_fq, sda_fq;
    logic              scl_upd, sda_upd;
    logic              rise_q, fall_q;
    logic              start_q, stop_q;
    logic              busy_q;
    logic              tmo_q;
    logic              tmo_rise;
    logic              start_c, stop_c;

    assign scl_upd = (scl_s2 != scl_fq) && (scl_cnt >= filt_len);
    assign sda_upd = (sda_s2 != sda_fq) && (sda_cnt >= filt_len);

    // SDA change while SCL is stably high; a same-cycle SCL update masks it
    assign start_c = sda_upd & ~sda_s2 & scl_fq & ~scl_upd;
    assign stop_c  = sda_upd &  sda_s2 & scl_fq & ~scl_upd;

    // Two-flop synchronisers, idle-high
    always_ff @(posedge wclk) begin
        if (srst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_in;
            scl_s2 <= scl_s1;
            sda_s1 <= bus.sda_in;
            sda_s2 <= sda_s1;
        end
    end

    // Spike filters: accept a new level once it outlasts filt_len cycles
    always_ff @(posedge wclk) begin
        if (srst) begin
            scl_cnt <= '0;
            scl_fq  <= 1'b1;
            sda_cnt <= '0;
            sda_fq  <= 1'b1;
        end else begin
            if (scl_s2 == scl_fq) begin
                scl_cnt <= '0;
            end else if (scl_upd) begin
                scl_fq  <= scl_s2;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + FILT_W'(1);
            end
            if (sda_s2 == sda_fq) begin
                sda_cnt <= '0;
            end else if (sda_upd) begin
                sda_fq  <= sda_s2;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + FILT_W'(1);
            end
        end
    end

    // Strobes and busy flag, aligned with the new filtered levels
    always_ff @(posedge wclk) begin
        if (srst) begin
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q  <= scl_upd &  scl_s2;
            fall_q  <= scl_upd & ~scl_s2;
            start_q <= start_c;
            stop_q  <= stop_c;
            if (start_c) begin
                busy_q <= 1'b1;
            end else if (stop_c || tmo_rise) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef I2C_BUS_FILTER_SCL_TMO_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic             tmo_hit;

    assign tmo_nxt  = (&tmo_cnt) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    assign tmo_hit  = ~scl_fq && (tmo_len != '0) && (tmo_nxt >= tmo_len);
    assign tmo_rise = tmo_hit & ~tmo_q & ~scl_upd;

    // Saturating SCL-low counter; flag holds until SCL is accepted high
    always_ff @(posedge wclk) begin
        if (srst) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_cnt <= scl_fq ? '0 : tmo_nxt;
            if (scl_fq || scl_upd || (tmo_len == '0)) begin
                tmo_q <= 1'b0;
            end else if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo_len;

    assign unused_tmo_len = ^tmo_len;
    assign tmo_q          = 1'b0;
    assign tmo_rise       = 1'b0;
`endif

    assign bus.scl_f     = scl_fq;
    assign bus.sda_f     = sda_fq;
    assign bus.scl_rise  = rise_q;
    assign bus.scl_fall  = fall_q;
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;
    assign bus.bus_busy  = busy_q;
    assign bus.scl_tmo   = tmo_q;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Directed bench for i2c_bus_filter.
// Timeout expectations follow I2C_BUS_FILTER_SCL_TMO_EN.
module tb_i2c_bus_filter;

    logic        wclk = 1'b0;
    logic        srst;
    logic [3:0]  filt_len;
    logic [15:0] tmo_len;

    int checks = 0;
    int errors = 0;

    logic seen_rise, seen_fall, seen_start, seen_stop;

`ifdef I2C_BUS_FILTER_SCL_TMO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    i2c_bus_filter_if bus ();

    i2c_bus_filter #(
        .FILT_W (4),
        .TMO_W  (16)
    ) dut (
        .wclk     (wclk),
        .srst     (srst),
        .filt_len (filt_len),
        .tmo_len  (tmo_len),
        .bus      (bus)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic clr_seen();
        seen_rise  = 1'b0;
        seen_fall  = 1'b0;
        seen_start = 1'b0;
        seen_stop  = 1'b0;
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            tick(1);
            seen_rise  = seen_rise  | bus.scl_rise;
            seen_fall  = seen_fall  | bus.scl_fall;
            seen_start = seen_start | bus.start_det;
            seen_stop  = seen_stop  | bus.stop_det;
        end
    endtask

    initial begin
        srst       = 1'b1;
        filt_len   = 4'd4;
        tmo_len    = 16'd0;
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        clr_seen();
        tick(3);
        chk("rst_scl_f", bus.scl_f, 1);
        chk("rst_sda_f", bus.sda_f, 1);
        chk("rst_strobes", {bus.scl_rise, bus.scl_fall,
                            bus.start_det, bus.stop_det}, 0);
        chk("rst_busy", bus.bus_busy, 0);
        chk("rst_tmo", bus.scl_tmo, 0);
        srst = 1'b0;

        // idle
        watch(50);
        chk("idle_strobes", {seen_rise, seen_fall, seen_start, seen_stop}, 0);
        chk("idle_levels", {bus.scl_f, bus.sda_f}, 2'b11);
        chk("idle_busy", bus.bus_busy, 0);

        // spike rejection, filt_len 4
        clr_seen();
        bus.scl_in = 1'b0;
        tick(4);
        bus.scl_in = 1'b1;
        watch(12);
        chk("spike4_fall", seen_fall, 0);
        chk("spike4_scl_f", bus.scl_f, 1);
        bus.scl_in = 1'b0;
        tick(5);
        bus.scl_in = 1'b1;
        tick(1);
        chk("pulse5_fall_early", bus.scl_fall, 0);
        tick(1);
        chk("pulse5_fall", bus.scl_fall, 1);
        chk("pulse5_scl_f", bus.scl_f, 0);
        tick(4);
        chk("pulse5_rise_early", bus.scl_rise, 0);
        tick(1);
        chk("pulse5_rise", bus.scl_rise, 1);
        chk("pulse5_scl_f_hi", bus.scl_f, 1);
        tick(1);
        chk("pulse5_rise_width", bus.scl_rise, 0);

        // START / STOP, filt_len 2
        filt_len = 4'd2;
        tick(2);
        bus.sda_in = 1'b0;
        tick(4);
        chk("start_early", bus.start_det, 0);
        tick(1);
        chk("start_det", bus.start_det, 1);
        chk("start_busy", bus.bus_busy, 1);
        tick(1);
        chk("start_width", bus.start_det, 0);
        chk("busy_hold", bus.bus_busy, 1);
        tick(4);
        bus.sda_in = 1'b1;
        tick(5);
        chk("stop_det", bus.stop_det, 1);
        chk("stop_busy", bus.bus_busy, 0);
        tick(1);
        chk("stop_width", bus.stop_det, 0);

        // repeated START
        bus.sda_in = 1'b0;
        tick(6);
        bus.scl_in = 1'b0;
        tick(6);
        bus.sda_in = 1'b1;
        tick(6);
        bus.scl_in = 1'b1;
        tick(6);
        chk("rs_busy_before", bus.bus_busy, 1);
        bus.sda_in = 1'b0;
        tick(5);
        chk("rs_start", bus.start_det, 1);
        chk("rs_busy", bus.bus_busy, 1);
        tick(2);
        bus.sda_in = 1'b1;
        tick(6);
        chk("rs_stop_busy", bus.bus_busy, 0);

        // simultaneous SCL/SDA fall, filt_len 0
        filt_len = 4'd0;
        tick(2);
        clr_seen();
        bus.scl_in = 1'b0;
        bus.sda_in = 1'b0;
        tick(2);
        chk("sim_fall_early", bus.scl_fall, 0);
        tick(1);
        chk("sim_fall", bus.scl_fall, 1);
        chk("sim_sda_f", bus.sda_f, 0);
        chk("sim_no_start", bus.start_det, 0);
        watch(5);
        chk("sim_no_start_later", seen_start, 0);
        chk("sim_busy", bus.bus_busy, 0);
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        tick(5);

        // SCL-low timeout, tmo_len 100
        filt_len = 4'd2;
        tmo_len  = 16'd100;
        tick(2);
        bus.sda_in = 1'b0;
        tick(6);
        chk("tmo_busy_start", bus.bus_busy, 1);
        bus.scl_in = 1'b0;
        tick(5);
        chk("tmo_scl_fall", bus.scl_fall, 1);
        tick(99);
        chk("tmo_early", bus.scl_tmo, 0);
        tick(1);
        chk("tmo_set", bus.scl_tmo, TMO_EN);
        chk("tmo_busy", bus.bus_busy, !TMO_EN);
        tick(395);
        chk("tmo_hold", bus.scl_tmo, TMO_EN);
        bus.scl_in = 1'b1;
        tick(4);
        chk("tmo_hold_rel", bus.scl_tmo, TMO_EN);
        tick(1);
        chk("tmo_rel_scl_f", bus.scl_f, 1);
        chk("tmo_clear", bus.scl_tmo, 0);
        bus.sda_in = 1'b1;
        tick(6);
        chk("tmo_end_busy", bus.bus_busy, 0);

        // reset mid-byte
        tmo_len = 16'd0;
        bus.sda_in = 1'b0;
        tick(6);
        bus.scl_in = 1'b0;
        tick(6);
        chk("mid_busy", bus.bus_busy, 1);
        chk("mid_scl_f", bus.scl_f, 0);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        chk("mid_rst_levels", {bus.scl_f, bus.sda_f}, 2'b11);
        chk("mid_rst_busy", bus.bus_busy, 0);
        chk("mid_rst_strobes", {bus.scl_rise, bus.scl_fall,
                                bus.start_det, bus.stop_det}, 0);
        clr_seen();
        watch(4);
        chk("mid_fall_early", seen_fall, 0);
        tick(1);
        chk("mid_fall", bus.scl_fall, 1);
        chk("mid_no_start", bus.start_det | seen_start, 0);
        chk("mid_no_stop", bus.stop_det | seen_stop, 0);
        chk("mid_sda_f", bus.sda_f, 0);
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        tick(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_bus_filter.md
# i2c_bus_filter

Input conditioning stage for the I2C controllers. It sits directly upstream of `i2c_master` (`scl_in`/`sda_in`) and `i2c_slave` (`sscl_in`/`ssda_in`). It synchronises the raw bus lines into `wclk`, rejects spikes shorter than a programmable length, and produces clean levels plus one-cycle SCL edge, START and STOP strobes and a bus-busy flag. An optional SCL-stuck-low timeout lets the controllers abort a hung bus.

## Interface
- `FILT_W`, 4: width of spike-filter counter and `filt_len`
- `TMO_W`, 16: width of timeout counter and `tmo_len`

- `wclk`  in  1  system clock; all logic on rising edge
- `srst`  in  1  synchronous reset, active-high
- `filt_len`  in  FILT_W  spike length to reject, in `wclk` cycles; 0 = no filtering beyond sync
- `tmo_len`  in  TMO_W  SCL-low timeout in `wclk` cycles; 0 = timeout disabled
- `scl_in`  in  1  raw SCL, asynchronous
- `sda_in`  in  1  raw SDA, asynchronous
- `scl_f`  out  1  filtered SCL level
- `sda_f`  out  1  filtered SDA level
- `scl_rise`  out  1  one-cycle strobe, SCL accepted 0→1
- `scl_fall`  out  1  one-cycle strobe, SCL accepted 1→0
- `start_det`  out  1  one-cycle strobe, START or repeated START
- `stop_det`  out  1  one-cycle strobe, STOP
- `bus_busy`  out  1  set between START and STOP
- `scl_tmo`  out  1  SCL held low ≥ `tmo_len` cycles

## Operation
- Each line passes through a 2-flop synchroniser, `s1`→`s2`. Both flops reset to 1.
- Per-line filter, with counter `cnt` and accepted level `f`:
  - `s2 == f`: `cnt <= 0`.
  - `s2 != f` and `cnt >= filt_len`: `f <= s2`, `cnt <= 0`. This is an "update".
  - Otherwise: `cnt <= cnt + 1`.
  - The `>=` comparison keeps the filter safe if `filt_len` is lowered mid-count.
- `scl_rise`/`scl_fall` are registered. They are high exactly in the first cycle `scl_f` shows its new value.
- `start_det`: SDA update to 0 while `scl_f` is 1 and SCL has no update in the same cycle.
- `stop_det`: SDA update to 1 while `scl_f` is 1 and SCL has no update in the same cycle.
- Simultaneous SCL and SDA update in one cycle:
  - Both levels are updated and the SCL edge strobe fires.
  - No START or STOP is reported.
- Strobe timing: `start_det`/`stop_det` are high in the first cycle `sda_f` shows its new value.
- `bus_busy`:
  - Set in the same cycle `start_det` is high.
  - Cleared in the same cycle `stop_det` is high.
  - A repeated START while busy pulses `start_det`; busy stays 1.
  - A STOP while idle pulses `stop_det`; busy stays 0.

## Timing
- Reset values:
  - `scl_f` = `sda_f` = 1.
  - All strobes 0, `bus_busy` 0, `scl_tmo` 0.
  - All counters 0, sync flops 1.
- Latency, raw input change to filtered output: `filt_len` + 3 `wclk` cycles. That is 2 sync cycles plus `filt_len` + 1 filter cycles.
- Spike rejection:
  - A pulse stable in `s2` for ≤ `filt_len` cycles is discarded.
  - A pulse stable for `filt_len` + 1 cycles is accepted.
- Strobes are exactly one cycle wide. Back-to-back updates can produce strobes in consecutive cycles only when `filt_len` = 0.
- `srst` mid-transaction:
  - All state returns to reset values in the next cycle.
  - No STOP is synthesised.
  - After release, a line that is already 0 is accepted after the normal filter latency. Its `scl_fall` fires, but no `start_det`, because `sda_f` was 1 at reset and SCL updates first or simultaneously.

## Configuration
- Macro: `I2C_BUS_FILTER_SCL_TMO_EN`.
- Defined:
  - A TMO_W counter increments each cycle `scl_f` = 0 and saturates.
  - It clears to 0 when `scl_f` = 1.
  - When the counter reaches `tmo_len` (non-zero) with `scl_f` = 0, `scl_tmo` asserts and holds until `scl_f` updates to 1.
  - `bus_busy` clears in the cycle `scl_tmo` rises.
  - `tmo_len` = 0 keeps `scl_tmo` at 0.
- Undefined: no counter is built, `scl_tmo` is constant 0, and `tmo_len` is ignored.

## Test plan
- Reset then idle with `filt_len` = 4: both inputs 1 for 50 cycles → `scl_f` = `sda_f` = 1, all strobes 0, `bus_busy` 0.
- Spike rejection, `filt_len` = 4: SCL low pulses of 4 cycles → no `scl_fall`; 5-cycle pulse → `scl_fall` 7 cycles after the input fell, `scl_rise` 7 cycles after it rose.
- START/STOP, `filt_len` = 2, SCL high, SDA 1→0, then 10 cycles later 0→1:
  - `start_det` and `bus_busy` high 5 cycles after the fall.
  - `stop_det` pulses and `bus_busy` drops 5 cycles after the rise.
- Repeated START and simultaneous edges:
  - START, SCL low, SDA 1, SCL high, SDA low → second `start_det`, `bus_busy` held 1.
  - SCL and SDA driven low on the same edge with `filt_len` = 0 → `scl_fall` only, no `start_det`.
- Timeout (macro defined), `tmo_len` = 100:
  - After START, hold SCL low 500 cycles → `scl_tmo` = 1 at 100 low cycles of `scl_f` and `bus_busy` = 0.
  - Release SCL → `scl_tmo` clears when `scl_f` = 1.
  - Macro undefined → `scl_tmo` stays 0.
- Reset mid-byte: assert `srst` for 1 cycle while busy with SCL low → next cycle all outputs at reset values, no `stop_det`; `scl_fall` follows after `filt_len` + 3 cycles.
